alu_seq: RTL
============

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; the block SHALL support any WIDTH from 4 to 32.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  operation request present.
REQ-005 in_ready  output  1  block SHALL accept a request this cycle.
REQ-006 operand_A  input  WIDTH  first operand.
REQ-007 operand_B  input  WIDTH  second operand or shift amount.
REQ-008 alu_control  input  4  opcode: 0001 ADD, 0010 SUB, 0011 AND, 0100 OR, 0101 XOR, 0110 SHL, 0111 SHR, 1000 MUL; all others illegal.
REQ-009 out_valid  output  1  result and flags valid.
REQ-010 out_ready  input  1  consumer takes the result.
REQ-011 result  output  WIDTH  registered result.
REQ-012 flag_z, flag_n, flag_c, flag_v  output  1 each  zero, negative, carry/borrow, signed overflow.
REQ-013 illegal  output  1  accepted opcode was illegal.

Function
REQ-014 The FSM SHALL have states IDLE, BUSY and DONE; in_ready SHALL be 1 only in IDLE.
REQ-015 Accept occurs on a rising edge with in_valid=1 and in_ready=1; operands and opcode SHALL be captured then, and input changes afterwards SHALL have no effect.
REQ-016 ADD, SUB, AND, OR, XOR and illegal opcodes SHALL go IDLE->DONE: out_valid=1 one cycle after accept.
REQ-017 SHL/SHR amount n = operand_B mod WIDTH; n=0 SHALL go directly to DONE (latency 1); n>0 SHALL spend n cycles in BUSY, shifting one bit per cycle with zero fill, then go to DONE (latency n+1).
REQ-018 MUL SHALL use iterative shift-add over exactly WIDTH BUSY cycles (latency WIDTH+1); result = low WIDTH bits of the unsigned product.
REQ-019 In DONE, result, flags and illegal SHALL stay stable until out_valid=1 and out_ready=1 on a rising edge; the FSM SHALL then enter IDLE, and a new request SHALL NOT be accepted in that same cycle.
REQ-020 flag_z = (result==0); flag_n = result[WIDTH-1].
REQ-021 flag_c: ADD carry-out; SUB borrow (A<B unsigned); SHL/SHR last bit shifted out (0 when n=0); MUL 1 if the upper WIDTH product bits are nonzero; 0 for all other opcodes.
REQ-022 flag_v: ADD/SUB two's-complement signed overflow; 0 for all other opcodes.
REQ-023 Illegal opcode SHALL produce result=0, flag_z=1, the other flags 0 and illegal=1; illegal SHALL be 0 for legal opcodes.
REQ-024 ADD/SUB SHALL wrap modulo 2^WIDTH.

Reset
REQ-025 Asserting reset SHALL immediately force IDLE, result=0, all flags=0, illegal=0, out_valid=0 and in_ready=1, including in the middle of BUSY.
REQ-026 After reset deasserts, the first rising edge with in_valid=1 SHALL accept a request.

Configuration
REQ-027 Macro ALU_SEQ_MUL_EN: when defined, MUL SHALL behave per REQ-018.
REQ-028 When ALU_SEQ_MUL_EN is not defined, opcode 1000 SHALL be treated as illegal per REQ-023 with latency 1, and the multiplier datapath SHALL be absent.

Verification (WIDTH=8)
REQ-029 ADD A=0x7F, B=0x01 -> after 1 cycle out_valid=1, result=0x80, N=1, V=1, C=0, Z=0.
REQ-030 SUB A=0x00, B=0x01 -> result=0xFF, C=1, N=1, V=0, latency 1.
REQ-031 SHL A=0x81, B=3 -> out_valid 4 cycles after accept, result=0x08, C=0; SHR A=0x81, B=1 -> result=0x40, C=1, latency 2.
REQ-032 MUL A=0x10, B=0x10 with ALU_SEQ_MUL_EN -> latency 9, result=0x00, Z=1, C=1; without the macro -> latency 1, illegal=1, result=0.
REQ-033 Hold out_ready=0 for 5 cycles in DONE while in_valid=1 with new operands -> result and flags unchanged, in_ready=0; with out_ready=1 -> IDLE, the pending request is accepted on the following edge.
REQ-034 Assert reset 3 cycles into MUL -> out_valid=0, result=0 and in_ready=1 immediately; a subsequent ADD 0x02+0x03 -> result 0x05.

Source files
------------

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle logic/arith ops, bit-serial shifts and an optional shift-add multiplier.
// Define ALU_SEQ_MUL_EN to build the multiplier; without it opcode 1000 is reported as illegal.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand_A,
    input  logic [WIDTH-1:0] operand_B,
    input  logic [3:0]       alu_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v,
    output logic             illegal
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_OR  = 4'b0100;
    localparam logic [3:0] OP_XOR = 4'b0101;
    localparam logic [3:0] OP_SHL = 4'b0110;
    localparam logic [3:0] OP_SHR = 4'b0111;
`ifdef ALU_SEQ_MUL_EN
    localparam logic [3:0] OP_MUL = 4'b1000;
`endif

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_reg;
    logic [3:0]       op_reg;
    logic [WIDTH-1:0] shift_reg;
    logic [CW-1:0]    cnt_reg;

    logic [CW-1:0]    shamt;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic [WIDTH-1:0] acc_res;
    logic             acc_c;
    logic             acc_v;
    logic             acc_ill;
    logic             acc_busy;
    logic [WIDTH-1:0] step_res;
    logic             step_c;

    assign in_ready = (state_reg == IDLE);
    assign shamt    = CW'(32'(operand_B) % 32'(WIDTH));
    assign sum_ext  = {1'b0, operand_A} + {1'b0, operand_B};
    assign diff_ext = {1'b0, operand_A} - {1'b0, operand_B};

    // Outcome of an accepted request when it completes in a single cycle.
    always_comb begin
        acc_res  = '0;
        acc_c    = 1'b0;
        acc_v    = 1'b0;
        acc_ill  = 1'b0;
        acc_busy = 1'b0;
        case (alu_control)
            OP_ADD: begin
                acc_res = sum_ext[WIDTH-1:0];
                acc_c   = sum_ext[WIDTH];
                acc_v   = (operand_A[WIDTH-1] == operand_B[WIDTH-1]) &&
                          (sum_ext[WIDTH-1] != operand_A[WIDTH-1]);
            end
            OP_SUB: begin
                acc_res = diff_ext[WIDTH-1:0];
                acc_c   = diff_ext[WIDTH];
                acc_v   = (operand_A[WIDTH-1] != operand_B[WIDTH-1]) &&
                          (diff_ext[WIDTH-1] != operand_A[WIDTH-1]);
            end
            OP_AND: acc_res = operand_A & operand_B;
            OP_OR:  acc_res = operand_A | operand_B;
            OP_XOR: acc_res = operand_A ^ operand_B;
            OP_SHL, OP_SHR: begin
                acc_res  = operand_A;
                acc_busy = (shamt != '0);
            end
`ifdef ALU_SEQ_MUL_EN
            OP_MUL: acc_busy = 1'b1;
`endif
            default: acc_ill = 1'b1;
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    // Product register starts as {0, B}; each step adds A into the high half when
    // the low bit is set, then shifts right. shift_reg holds A for the whole multiply.
    logic [2*WIDTH-1:0] prod_reg;
    logic [WIDTH:0]     prod_sum;
    logic [2*WIDTH-1:0] prod_next;

    assign prod_sum  = {1'b0, prod_reg[2*WIDTH-1:WIDTH]} +
                       (prod_reg[0] ? {1'b0, shift_reg} : {(WIDTH+1){1'b0}});
    assign prod_next = {prod_sum, prod_reg[WIDTH-1:1]};
`endif

    always_comb begin
        step_res = {shift_reg[WIDTH-2:0], 1'b0};
        step_c   = shift_reg[WIDTH-1];
        if (op_reg == OP_SHR) begin
            step_res = {1'b0, shift_reg[WIDTH-1:1]};
            step_c   = shift_reg[0];
        end
`ifdef ALU_SEQ_MUL_EN
        if (op_reg == OP_MUL) begin
            step_res = prod_next[WIDTH-1:0];
            step_c   = |prod_next[2*WIDTH-1:WIDTH];
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            op_reg    <= '0;
            shift_reg <= '0;
            cnt_reg   <= '0;
            result    <= '0;
            flag_z    <= 1'b0;
            flag_n    <= 1'b0;
            flag_c    <= 1'b0;
            flag_v    <= 1'b0;
            illegal   <= 1'b0;
            out_valid <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            prod_reg  <= '0;
`endif
        end else begin
            case (state_reg)
                IDLE: if (in_valid) begin
                    op_reg    <= alu_control;
                    shift_reg <= operand_A;
                    cnt_reg   <= shamt;
`ifdef ALU_SEQ_MUL_EN
                    prod_reg  <= {{WIDTH{1'b0}}, operand_B};
                    if (alu_control == OP_MUL)
                        cnt_reg <= CW'(WIDTH);
`endif
                    if (acc_busy) begin
                        state_reg <= BUSY;
                    end else begin
                        state_reg <= DONE;
                        out_valid <= 1'b1;
                        result    <= acc_res;
                        flag_z    <= (acc_res == '0);
                        flag_n    <= acc_res[WIDTH-1];
                        flag_c    <= acc_c;
                        flag_v    <= acc_v;
                        illegal   <= acc_ill;
                    end
                end
                BUSY: begin
                    cnt_reg <= cnt_reg - CW'(1);
`ifdef ALU_SEQ_MUL_EN
                    prod_reg <= prod_next;
                    if (op_reg != OP_MUL)
                        shift_reg <= step_res;
`else
                    shift_reg <= step_res;
`endif
                    if (cnt_reg == CW'(1)) begin
                        state_reg <= DONE;
                        out_valid <= 1'b1;
                        result    <= step_res;
                        flag_z    <= (step_res == '0);
                        flag_n    <= step_res[WIDTH-1];
                        flag_c    <= step_c;
                        flag_v    <= 1'b0;
                        illegal   <= 1'b0;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
